dff_checker: RTL and testbench

DFF_CHECKER -- requirements
Module: dff_checker

---
 rtl/dff_checker_pkg.sv | 22 ++
 rtl/dff_checker_sat_counter.sv | 48 ++++
 rtl/dff_checker.sv | 111 +++++++++++
 tb/tb_dff_checker.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dff_checker_pkg.sv
// ============================================================================
// Module : dff_checker_pkg
// Brief  : FSM state encoding and counter widths shared by the flop checker.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package dff_checker_pkg;

  localparam int CHECK_W = 16;
  localparam int ERR_W   = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRIME = 2'd1,
    S_CHECK = 2'd2,
    S_FAIL  = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/dff_checker_sat_counter.sv
// ============================================================================
// Module : sat_counter
// Brief  : Up-counter that sticks at all-ones; clear wins over inc, hold freezes.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sat_counter
  import dff_checker_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clear,
  input  logic             hold,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] c_max = '1;

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_next;

  always_comb begin
    w_next = r_count;
    if (clear) begin
      w_next = '0;
    end else if (inc && !hold && (r_count != c_max)) begin
      w_next = r_count + 1'b1;
    end
  end

  // Register is rewritten every edge so a held value is always re-latched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else begin
      r_count <= w_next;
    end
  end

  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/dff_checker.sv
// ============================================================================
// Module : dff_checker
// Brief  : Online checker for a flop with true/complement outputs and async reset.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dff_checker
  import dff_checker_pkg::*;
#(
  parameter int WIDTH     = 1,
  parameter int ERR_LIMIT = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               dut_rst,
  input  logic [WIDTH-1:0]   d,
  input  logic [WIDTH-1:0]   q,
  input  logic [WIDTH-1:0]   qb,
  output logic [CHECK_W-1:0] checks,
  output logic [ERR_W-1:0]   errors,
  output logic               err_seen,
  output logic [CHECK_W-1:0] first_err_cycle,
  output logic               fail
);

  localparam logic [ERR_W-1:0] c_limit_m1 = ERR_W'(ERR_LIMIT - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_exp_q;
  logic [WIDTH-1:0]   w_cmp_val;
  logic               r_err_seen;
  logic               r_fail;
  logic [CHECK_W-1:0] r_first;
  logic               w_cmp;
  logic               w_mis;
  logic               w_err_inc;
  logic               w_hit_limit;
  logic               w_hold;

  // The flop's reset is asynchronous, so an asserted dut_rst overrides exp_q.
  assign w_cmp_val   = dut_rst ? '0 : r_exp_q;
  assign w_cmp       = (r_state == S_CHECK);
  assign w_mis       = (q != w_cmp_val) || (qb != ~q);
  assign w_err_inc   = w_cmp && w_mis;
  assign w_hit_limit = w_err_inc && (errors == c_limit_m1);
  assign w_hold      = (r_state == S_FAIL);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (en) w_state_nxt = S_PRIME;
      S_PRIME: w_state_nxt = en ? S_CHECK : S_IDLE;
      S_CHECK: if (!en) w_state_nxt = S_IDLE;
      S_FAIL:  w_state_nxt = S_FAIL;
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_hit_limit) begin
      w_state_nxt = S_FAIL;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_exp_q    <= '0;
      r_err_seen <= 1'b0;
      r_first    <= '0;
      r_fail     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (!w_hold) begin
        r_exp_q <= dut_rst ? '0 : d;
      end
      if (w_err_inc && !r_err_seen) begin
        r_err_seen <= 1'b1;
        r_first    <= checks;
      end
      if (w_hit_limit) begin
        r_fail <= 1'b1;
      end
    end
  end

  sat_counter #(.WIDTH(CHECK_W)) u_checks (
    .clk   (clk),
    .reset (reset),
    .inc   (w_cmp),
    .clear (1'b0),
    .hold  (w_hold),
    .count (checks)
  );

  sat_counter #(.WIDTH(ERR_W)) u_errors (
    .clk   (clk),
    .reset (reset),
    .inc   (w_err_inc),
    .clear (1'b0),
    .hold  (w_hold),
    .count (errors)
  );

  assign err_seen        = r_err_seen;
  assign first_err_cycle = r_first;
  assign fail            = r_fail;

endmodule

`default_nettype wire

// File: tb/tb_dff_checker.sv
// ============================================================================
// Module : tb_dff_checker
// Brief  : Self-checking bench: directed table, corner sequences, random vs model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dff_checker;
  import dff_checker_pkg::*;

  localparam int WIDTH     = 4;
  localparam int ERR_LIMIT = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic               en;
  logic               dut_rst;
  logic [WIDTH-1:0]   d;
  logic [WIDTH-1:0]   q;
  logic [WIDTH-1:0]   qb;
  logic [CHECK_W-1:0] checks;
  logic [ERR_W-1:0]   errors;
  logic               err_seen;
  logic [CHECK_W-1:0] first_err_cycle;
  logic               fail;

  dff_checker #(.WIDTH(WIDTH), .ERR_LIMIT(ERR_LIMIT)) dut (
    .clk             (clk),
    .reset           (reset),
    .en              (en),
    .dut_rst         (dut_rst),
    .d               (d),
    .q               (q),
    .qb              (qb),
    .checks          (checks),
    .errors          (errors),
    .err_seen        (err_seen),
    .first_err_cycle (first_err_cycle),
    .fail            (fail)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: a check happens when en was seen high on both previous edges.
  int               m_checks, m_errors, m_first;
  logic             m_seen, m_fail, m_en1, m_en2;
  logic [WIDTH-1:0] m_prev_exp;
  logic [WIDTH-1:0] f_q;

  typedef struct packed {
    logic               v_en;
    logic               v_rst;
    logic [WIDTH-1:0]   v_d;
    logic [WIDTH-1:0]   v_q;
    logic [WIDTH-1:0]   v_qb;
    logic [CHECK_W-1:0] x_checks;
    logic [ERR_W-1:0]   x_errors;
    logic               x_seen;
    logic [CHECK_W-1:0] x_first;
    logic               x_fail;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input int xc, input int xe, input logic xs,
                          input int xf, input logic xfl);
    chk({tag, ".checks"}, 32'(checks), xc);
    chk({tag, ".errors"}, 32'(errors), xe);
    chk({tag, ".err_seen"}, 32'(err_seen), 32'(xs));
    chk({tag, ".first_err_cycle"}, 32'(first_err_cycle), xf);
    chk({tag, ".fail"}, 32'(fail), 32'(xfl));
  endtask

  task automatic model_reset();
    m_checks = 0; m_errors = 0; m_first = 0;
    m_seen = 1'b0; m_fail = 1'b0; m_en1 = 1'b0; m_en2 = 1'b0;
    m_prev_exp = '0;
  endtask

  task automatic model_edge(input logic e, input logic r, input logic [WIDTH-1:0] dv,
                            input logic [WIDTH-1:0] qv, input logic [WIDTH-1:0] qbv);
    logic [WIDTH-1:0] cmpv;
    logic mis;
    if (m_fail) return;
    if (m_en1 && m_en2) begin
      cmpv = r ? '0 : m_prev_exp;
      mis  = (qv != cmpv) || (qbv != ~qv);
      if (mis && !m_seen) begin
        m_seen  = 1'b1;
        m_first = m_checks;
      end
      m_checks = (m_checks < 65535) ? m_checks + 1 : m_checks;
      if (mis) begin
        m_errors = (m_errors < 255) ? m_errors + 1 : m_errors;
        if (m_errors == ERR_LIMIT) m_fail = 1'b1;
      end
    end
    m_prev_exp = r ? '0 : dv;
    m_en2 = m_en1;
    m_en1 = e;
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input logic e, input logic r, input logic [WIDTH-1:0] dv,
                      input logic [WIDTH-1:0] qv, input logic [WIDTH-1:0] qbv);
    en = e; dut_rst = r; d = dv; q = qv; qb = qbv;
    model_edge(e, r, dv, qv, qbv);
    @(posedge clk);
    f_q = r ? '0 : dv;
    @(negedge clk);
  endtask

  task automatic ideal(input logic e, input logic r, input logic [WIDTH-1:0] dv);
    logic [WIDTH-1:0] qv;
    qv = r ? '0 : f_q;
    step(e, r, dv, qv, ~qv);
  endtask

  task automatic do_reset();
    reset = 1'b0; en = 1'b0; dut_rst = 1'b0; d = '0; q = '0; qb = '1;
    #2;
    model_reset();
    f_q = '0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 4'h5, 4'h0, 4'hF, 16'd0, 8'd0, 1'b0, 16'd0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 4'hA, 4'h5, 4'hA, 16'd0, 8'd0, 1'b0, 16'd0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 4'h3, 4'hA, 4'h5, 16'd1, 8'd0, 1'b0, 16'd0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 4'hC, 4'h3, 4'h3, 16'd2, 8'd1, 1'b1, 16'd1, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 4'h7, 4'h0, 4'hF, 16'd3, 8'd1, 1'b1, 16'd1, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 4'h9, 4'h0, 4'hF, 16'd4, 8'd1, 1'b1, 16'd1, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 4'h6, 4'h0, 4'hF, 16'd5, 8'd1, 1'b1, 16'd1, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 4'hE, 4'h0, 4'hF, 16'd6, 8'd1, 1'b1, 16'd1, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 4'h1, 4'hE, 4'h1, 16'd7, 8'd1, 1'b1, 16'd1, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 4'h2, 4'h1, 4'hE, 16'd8, 8'd1, 1'b1, 16'd1, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 4'h4, 4'hF, 4'h0, 16'd8, 8'd1, 1'b1, 16'd1, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 4'h8, 4'h0, 4'h0, 16'd8, 8'd1, 1'b1, 16'd1, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 4'hB, 4'h0, 4'h0, 16'd8, 8'd1, 1'b1, 16'd1, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 4'h0, 4'hB, 4'h4, 16'd9, 8'd1, 1'b1, 16'd1, 1'b0};

    // Reset values
    reset = 1'b0; en = 1'b0; dut_rst = 1'b0; d = '0; q = '0; qb = '1;
    model_reset();
    f_q = '0;
    @(negedge clk);
    chk_outs("reset", 0, 0, 1'b0, 0, 1'b0);
    chk("reset.state", 32'(dut.r_state), 32'(S_IDLE));
    reset = 1'b1;

    // Directed table: compare, qb fault, dut_rst pulse, en drop, re-prime
    for (int i = 0; i < 14; i++) begin
      step(tbl[i].v_en, tbl[i].v_rst, tbl[i].v_d, tbl[i].v_q, tbl[i].v_qb);
      chk_outs($sformatf("tbl%0d", i), 32'(tbl[i].x_checks), 32'(tbl[i].x_errors),
               tbl[i].x_seen, 32'(tbl[i].x_first), tbl[i].x_fail);
    end

    // Ideal flop, d toggling for 20 edges
    do_reset();
    for (int i = 0; i < 20; i++) ideal(1'b1, 1'b0, (i % 2 == 0) ? 4'h1 : 4'h0);
    chk_outs("toggle20", 18, 0, 1'b0, 0, 1'b0);

    // q stuck high: fail after ERR_LIMIT errors, then everything freezes
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 4'h0, 4'hF, 4'h0);
    chk_outs("stuck", 4, 4, 1'b1, 0, 1'b1);
    chk("stuck.state", 32'(dut.r_state), 32'(S_FAIL));
    do_reset();
    chk("fail_exit.state", 32'(dut.r_state), 32'(S_IDLE));
    chk("fail_exit.fail", 32'(fail), 32'd0);

    // Async reset between edges with two errors outstanding
    ideal(1'b1, 1'b0, 4'h6);
    ideal(1'b1, 1'b0, 4'h9);
    step(1'b1, 1'b0, 4'h2, f_q, f_q);
    step(1'b1, 1'b0, 4'h5, f_q, f_q);
    chk_outs("pre_areset", 2, 2, 1'b1, 0, 1'b0);
    reset = 1'b0;
    #2;
    model_reset();
    chk_outs("areset", 0, 0, 1'b0, 0, 1'b0);
    #1;
    reset = 1'b1;
    ideal(1'b1, 1'b0, 4'h3);
    chk("areset.edge1", 32'(checks), 32'd0);
    ideal(1'b1, 1'b0, 4'h7);
    chk("areset.edge2", 32'(checks), 32'd0);
    ideal(1'b1, 1'b0, 4'h1);
    chk("areset.edge3", 32'(checks), 32'd1);
    chk("areset.errors", 32'(errors), 32'd0);

    // Saturation of checks from a preloaded value
    do_reset();
    force dut.u_checks.r_count = 16'hFFFE;
    @(posedge clk);
    @(negedge clk);
    release dut.u_checks.r_count;
    chk("sat.preload", 32'(checks), 32'hFFFE);
    ideal(1'b1, 1'b0, 4'h2);
    ideal(1'b1, 1'b0, 4'h4);
    ideal(1'b1, 1'b0, 4'h8);
    chk("sat.first", 32'(checks), 32'hFFFF);
    ideal(1'b1, 1'b0, 4'h3);
    ideal(1'b1, 1'b0, 4'h5);
    chk("sat.hold", 32'(checks), 32'hFFFF);
    chk("sat.errors", 32'(errors), 32'd0);

    // Randomized traffic against the reference model
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic             e, r;
      logic [WIDTH-1:0] dv, qv, qbv;
      if (cyc % 150 == 0) do_reset();
      e   = ($urandom_range(0, 7) != 0);
      r   = ($urandom_range(0, 9) == 0);
      dv  = WIDTH'($urandom);
      qv  = r ? '0 : f_q;
      qbv = ~qv;
      if ($urandom_range(0, 29) == 0) qv  = qv  ^ (4'h1 << $urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) qbv = qbv ^ (4'h1 << $urandom_range(0, 3));
      step(e, r, dv, qv, qbv);
      chk_outs($sformatf("rand%0d", cyc), m_checks, m_errors, m_seen, m_first, m_fail);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
